otp_input_conditioner: RTL and testbench



---
 rtl/otp_pkg.sv | 23 ++
 rtl/otp_input_conditioner_if.sv | 24 ++
 rtl/otp_input_conditioner_debounce_chan.sv | 70 +++++++
 rtl/otp_input_conditioner.sv | 103 ++++++++++
 tb/tb_otp_input_conditioner.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/otp_pkg.sv
// Shared types and timing constants for the OTP authenticator input front end.
package otp_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        LONG    = 2'd2
    } btn_state_t;

    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_DB_CYCLES   = 1000000;
    localparam int DEF_LONG_CYCLES = 100000000;

    // Short timing set so simulation sees debounce and long-press within a few dozen cycles.
    localparam int SIM_SYNC_STAGES = 2;
    localparam int SIM_DB_CYCLES   = 4;
    localparam int SIM_LONG_CYCLES = 16;

    function automatic int cnt_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/otp_input_conditioner_if.sv
// Raw board inputs and conditioned outputs of the OTP input front end.
interface otp_input_conditioner_if;
    import otp_pkg::*;

    logic [3:0] sw_raw;
    logic       otp_btn_raw;
    logic       user_btn_raw;
    logic [3:0] sw_db;
    logic       otp_latch;
    logic       user_latch;
    logic       clear_pulse;
    logic       busy;

    modport master (
        output sw_raw, otp_btn_raw, user_btn_raw,
        input  sw_db, otp_latch, user_latch, clear_pulse, busy
    );

    modport slave (
        input  sw_raw, otp_btn_raw, user_btn_raw,
        output sw_db, otp_latch, user_latch, clear_pulse, busy
    );

endinterface

// File: rtl/otp_input_conditioner_debounce_chan.sv
// One debounce channel: synchroniser chain, stability counter and debounced value register.
// db_next_o is the value the debounced register takes on the next edge.
module debounce_chan
    import otp_pkg::*;
#(
    parameter int WIDTH       = 1,
    parameter int SYNC_STAGES = 2,
    parameter int DB_CYCLES   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] raw_i,
    output logic [WIDTH-1:0] db_next_o,
    output logic             busy_o
);

    localparam int  CW         = cnt_width(DB_CYCLES);
    localparam bit  CLR_ON_CHG = (WIDTH > 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] db_q, db_d;
    logic             differ_s, change_s, load_s;

    // Synchroniser chain, one flop per stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= raw_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // A vector about to take a new synced value restarts its count, so bounces between digits never load.
    always_comb begin
        differ_s = (sync_q[SYNC_STAGES-1] != db_q);
        change_s = CLR_ON_CHG && (sync_q[SYNC_STAGES-2] != sync_q[SYNC_STAGES-1]);
        load_s   = differ_s && (cnt_q == CW'(DB_CYCLES - 1));
        db_d     = db_q;
        cnt_d    = '0;
        if (load_s) begin
            db_d  = sync_q[SYNC_STAGES-1];
            cnt_d = '0;
        end else if (!differ_s || change_s) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Stability counter and debounced value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            db_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            db_q  <= db_d;
        end
    end

    assign db_next_o = db_d;
    assign busy_o    = (cnt_q != '0);

endmodule

// File: rtl/otp_input_conditioner.sv
// OTP input front end: debounces switches and buttons, tracks presses and flags a long user press.
module otp_input_conditioner
    import otp_pkg::*;
#(
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int DB_CYCLES   = DEF_DB_CYCLES,
    parameter int LONG_CYCLES = DEF_LONG_CYCLES
) (
    input  logic                    clk,
    input  logic                    reset,
    otp_input_conditioner_if.slave  io
);

    localparam int HW = cnt_width(LONG_CYCLES);

    logic [3:0]  sw_next_s;
    logic        otp_next_s, user_next_s;
    logic        sw_busy_s, otp_busy_s, user_busy_s;
    btn_state_t  otp_state_q, otp_state_d, user_state_q, user_state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic        clr_d;
    logic [3:0]  sw_db_q;
    logic        otp_latch_q, user_latch_q, clear_q;

    debounce_chan #(.WIDTH(4), .SYNC_STAGES(SYNC_STAGES), .DB_CYCLES(DB_CYCLES)) u_sw (
        .clk(clk), .rst(reset), .raw_i(io.sw_raw), .db_next_o(sw_next_s), .busy_o(sw_busy_s)
    );
    debounce_chan #(.WIDTH(1), .SYNC_STAGES(SYNC_STAGES), .DB_CYCLES(DB_CYCLES)) u_otp (
        .clk(clk), .rst(reset), .raw_i(io.otp_btn_raw), .db_next_o(otp_next_s), .busy_o(otp_busy_s)
    );
    debounce_chan #(.WIDTH(1), .SYNC_STAGES(SYNC_STAGES), .DB_CYCLES(DB_CYCLES)) u_user (
        .clk(clk), .rst(reset), .raw_i(io.user_btn_raw), .db_next_o(user_next_s), .busy_o(user_busy_s)
    );

    // OTP button: press tracking only, no long-press behaviour.
    always_comb begin
        otp_state_d = otp_state_q;
        case (otp_state_q)
            IDLE:    if (otp_next_s)  otp_state_d = PRESSED; else otp_state_d = IDLE;
            PRESSED: if (!otp_next_s) otp_state_d = IDLE;    else otp_state_d = PRESSED;
            default: otp_state_d = IDLE;
        endcase
    end

    // User button: hold counter saturates at the long-press point, so the pulse fires once per press.
    always_comb begin
        user_state_d = user_state_q;
        hold_d       = hold_q;
        clr_d        = 1'b0;
        case (user_state_q)
            IDLE: begin
                if (user_next_s) begin
                    user_state_d = PRESSED;
                    hold_d       = '0;
                end else begin
                    user_state_d = IDLE;
                end
            end
            PRESSED: begin
                if (!user_next_s) begin
                    user_state_d = IDLE;
                end else if (hold_q == HW'(LONG_CYCLES - 1)) begin
                    user_state_d = LONG;
                    clr_d        = 1'b1;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            LONG: begin
                if (!user_next_s) user_state_d = IDLE; else user_state_d = LONG;
            end
            default: user_state_d = IDLE;
        endcase
    end

    // State, hold counter and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            otp_state_q  <= IDLE;
            user_state_q <= IDLE;
            hold_q       <= '0;
            sw_db_q      <= 4'h0;
            otp_latch_q  <= 1'b0;
            user_latch_q <= 1'b0;
            clear_q      <= 1'b0;
        end else begin
            otp_state_q  <= otp_state_d;
            user_state_q <= user_state_d;
            hold_q       <= hold_d;
            sw_db_q      <= sw_next_s;
            otp_latch_q  <= (otp_state_d != IDLE);
            user_latch_q <= (user_state_d != IDLE);
            clear_q      <= clr_d;
        end
    end

    assign io.sw_db       = sw_db_q;
    assign io.otp_latch   = otp_latch_q;
    assign io.user_latch  = user_latch_q;
    assign io.clear_pulse = clear_q;
    assign io.busy        = sw_busy_s | otp_busy_s | user_busy_s;

endmodule

// File: tb/tb_otp_input_conditioner.sv
// Directed bench for otp_input_conditioner with SYNC_STAGES=2, DB_CYCLES=4, LONG_CYCLES=16.
module tb_otp_input_conditioner;
    import otp_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    otp_input_conditioner_if bus();

    otp_input_conditioner #(
        .SYNC_STAGES(SIM_SYNC_STAGES),
        .DB_CYCLES(SIM_DB_CYCLES),
        .LONG_CYCLES(SIM_LONG_CYCLES)
    ) dut (
        .clk(clk),
        .reset(reset),
        .io(bus)
    );

    always #5 clk = ~clk;

    // Inputs are driven and outputs sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic inputs_low();
        bus.sw_raw       = 4'h0;
        bus.otp_btn_raw  = 1'b0;
        bus.user_btn_raw = 1'b0;
    endtask

    task automatic test_reset();
        inputs_low();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        repeat (3) tick();
        checks++;
        if ({bus.sw_db, bus.otp_latch, bus.user_latch, bus.clear_pulse} !== 7'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=0000000",
                     {bus.sw_db, bus.otp_latch, bus.user_latch, bus.clear_pulse});
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy got=%b exp=0", bus.busy);
        end
    endtask

    task automatic test_async_reset();
        bus.user_btn_raw = 1'b1;
        repeat (6) tick();
        checks++;
        if (bus.user_latch !== 1'b1) begin
            failures++;
            $display("FAIL async_pre_latch got=%b exp=1", bus.user_latch);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (bus.user_latch !== 1'b0) begin
            failures++;
            $display("FAIL async_reset_latch got=%b exp=0", bus.user_latch);
        end
        tick();
        reset = 1'b0;
        // Button still held: needs the full sync + debounce time again.
        for (int e = 1; e <= 7; e++) begin
            tick();
            checks++;
            if (bus.user_latch !== (e >= 6)) begin
                failures++;
                $display("FAIL rehold_latch e=%0d got=%b exp=%b", e, bus.user_latch, (e >= 6));
            end
        end
        bus.user_btn_raw = 1'b0;
        repeat (12) tick();
    endtask

    task automatic test_clean_step();
        bus.user_btn_raw = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            checks++;
            if (bus.user_latch !== (e >= 6)) begin
                failures++;
                $display("FAIL clean_step e=%0d user_latch=%b exp=%b", e, bus.user_latch, (e >= 6));
            end
            checks++;
            if ({bus.otp_latch, bus.sw_db} !== 5'b0) begin
                failures++;
                $display("FAIL clean_step_others e=%0d got=%b exp=00000", e, {bus.otp_latch, bus.sw_db});
            end
        end
        bus.user_btn_raw = 1'b0;
        repeat (12) tick();
        checks++;
        if ({bus.user_latch, bus.busy} !== 2'b00) begin
            failures++;
            $display("FAIL clean_release got=%b exp=00", {bus.user_latch, bus.busy});
        end
    endtask

    task automatic test_bounce();
        int  rises = 0;
        logic prev = 1'b0;
        for (int c = 0; c <= 21; c++) begin
            bus.otp_btn_raw = (c < 3) || (c >= 4 && c < 14);
            tick();
            checks++;
            if (bus.otp_latch !== ((c + 1) >= 10 && (c + 1) < 20)) begin
                failures++;
                $display("FAIL bounce e=%0d otp_latch=%b exp=%b", c + 1, bus.otp_latch,
                         ((c + 1) >= 10 && (c + 1) < 20));
            end
            if (bus.otp_latch && !prev) rises++;
            prev = bus.otp_latch;
        end
        checks++;
        if (rises != 1) begin
            failures++;
            $display("FAIL bounce_rises got=%0d exp=1", rises);
        end
        repeat (6) tick();
    endtask

    task automatic test_sw_change();
        for (int c = 0; c <= 11; c++) begin
            if (c == 0) bus.sw_raw = 4'h5;
            if (c == 2) bus.sw_raw = 4'hA;
            tick();
            checks++;
            if (bus.sw_db !== (((c + 1) >= 8) ? 4'hA : 4'h0)) begin
                failures++;
                $display("FAIL sw_change e=%0d sw_db=%h exp=%h", c + 1, bus.sw_db,
                         (((c + 1) >= 8) ? 4'hA : 4'h0));
            end
        end
        bus.sw_raw = 4'h0;
        repeat (12) tick();
        checks++;
        if (bus.sw_db !== 4'h0) begin
            failures++;
            $display("FAIL sw_return got=%h exp=0", bus.sw_db);
        end
    endtask

    task automatic test_long_press();
        int pulses = 0;
        for (int c = 0; c <= 49; c++) begin
            bus.user_btn_raw = (c < 40);
            tick();
            checks++;
            if (bus.user_latch !== ((c + 1) >= 6 && (c + 1) < 46)) begin
                failures++;
                $display("FAIL long_latch e=%0d got=%b exp=%b", c + 1, bus.user_latch,
                         ((c + 1) >= 6 && (c + 1) < 46));
            end
            checks++;
            if (bus.clear_pulse !== ((c + 1) == 22)) begin
                failures++;
                $display("FAIL long_clear e=%0d got=%b exp=%b", c + 1, bus.clear_pulse, ((c + 1) == 22));
            end
            if (bus.clear_pulse) pulses++;
        end
        checks++;
        if (pulses != 1) begin
            failures++;
            $display("FAIL long_pulse_count got=%0d exp=1", pulses);
        end
        repeat (6) tick();
    endtask

    task automatic test_simultaneous();
        bus.otp_btn_raw  = 1'b1;
        bus.user_btn_raw = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            tick();
            checks++;
            if ({bus.otp_latch, bus.user_latch} !== {2{e >= 6}}) begin
                failures++;
                $display("FAIL simul_latch e=%0d got=%b exp=%b", e, {bus.otp_latch, bus.user_latch},
                         {2{e >= 6}});
            end
            checks++;
            if (bus.busy !== (e >= 3 && e <= 5)) begin
                failures++;
                $display("FAIL simul_busy e=%0d got=%b exp=%b", e, bus.busy, (e >= 3 && e <= 5));
            end
        end
        inputs_low();
        repeat (12) tick();
        checks++;
        if ({bus.otp_latch, bus.user_latch, bus.busy} !== 3'b000) begin
            failures++;
            $display("FAIL simul_release got=%b exp=000", {bus.otp_latch, bus.user_latch, bus.busy});
        end
    endtask

    initial begin
        inputs_low();
        test_reset();
        test_async_reset();
        test_clean_step();
        test_bounce();
        test_sw_change();
        test_long_press();
        test_simultaneous();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
